// File: rtl/mips_pkg.sv
// Shared Micro_MIPS definitions: instruction-memory geometry used by both the
// fetch stage and the program loader, plus the loader state encoding.
package mips_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int INSTR_W     = 32;
    localparam int IMEM_WORDS  = 2 ** IMEM_ADDR_W;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_WRITE = 3'd3,
        LDR_CHK   = 3'd4,
        LDR_DONE  = 3'd5
    } ldr_state_t;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes into one big-endian (MIPS order) instruction
// word. The first byte received ends up in bits [31:24].
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] idx;

    // Shift bytes in MSB first; clear restarts the word at a load boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (clear) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (load) begin
            word <= {word[23:0], byte_in};
            idx  <= idx + 2'd1;
        end
    end

    // Asserted while the next loaded byte will be the 4th of the word.
    assign full = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader for the Micro_MIPS instruction memory. A byte stream
// (word count, then big-endian instruction bytes) is packed into words and
// written to memory while the core is held in reset.
// Optional feature macro: LOADER_CHKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter int WORDS  = IMEM_WORDS
) (
    input  logic              reloj,
    input  logic              resetM,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_di,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ldr_state_t        state, state_nxt;
    logic [ADDR_W:0]   target;
    logic [ADDR_W:0]   len_target;
    logic [ADDR_W-1:0] addr;
    logic              last_word;
    logic [31:0]       packed_word;
    logic              pk_full;
    logic              start_load, len_take, data_take, addr_step;
    logic              finish_ok, finish_bad, chk_match;

    byte_packer u_packer (
        .clk     (reloj),
        .rst_n   (resetM),
        .clear   (len_take),
        .load    (data_take),
        .byte_in (byte_data),
        .word    (packed_word),
        .full    (pk_full)
    );

    // A count of zero or one beyond the memory size means "fill the memory".
    always_comb begin
        if (byte_data == 8'd0 || 32'(byte_data) > 32'(WORDS))
            len_target = (ADDR_W+1)'(WORDS);
        else
            len_target = (ADDR_W+1)'(byte_data);
    end

    assign last_word = ((ADDR_W+1)'(addr) + (ADDR_W+1)'(1)) == target;
    assign imem_addr = addr;
    assign imem_di   = DATA_W'(packed_word);

    // State register.
    always_ff @(posedge reloj) begin
        if (!resetM)
            state <= LDR_IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the handshake, write strobe and datapath enables.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        start_load = 1'b0;
        len_take   = 1'b0;
        data_take  = 1'b0;
        addr_step  = 1'b0;
        finish_ok  = 1'b0;
        finish_bad = 1'b0;
        case (state)
            LDR_IDLE, LDR_DONE: begin
                if (start) begin
                    start_load = 1'b1;
                    state_nxt  = LDR_LEN;
                end
            end
            LDR_LEN: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    len_take  = 1'b1;
                    state_nxt = LDR_DATA;
                end
            end
            LDR_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    data_take = 1'b1;
                    if (pk_full)
                        state_nxt = LDR_WRITE;
                end
            end
            LDR_WRITE: begin
                imem_we = 1'b1;
                if (last_word) begin
`ifdef LOADER_CHKSUM_EN
                    state_nxt = LDR_CHK;
`else
                    finish_ok = 1'b1;
                    state_nxt = LDR_DONE;
`endif
                end else begin
                    addr_step = 1'b1;
                    state_nxt = LDR_DATA;
                end
            end
`ifdef LOADER_CHKSUM_EN
            LDR_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (chk_match) begin
                        finish_ok = 1'b1;
                        state_nxt = LDR_DONE;
                    end else begin
                        finish_bad = 1'b1;
                        state_nxt  = LDR_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = LDR_IDLE;
        endcase
    end

    // Word address, word count and the status flags seen by the core.
    always_ff @(posedge reloj) begin
        if (!resetM) begin
            target       <= '0;
            addr         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            core_reset_n <= 1'b0;
        end else begin
            if (start_load) begin
                busy         <= 1'b1;
                done         <= 1'b0;
                core_reset_n <= 1'b0;
            end
            if (len_take) begin
                target <= len_target;
                addr   <= '0;
            end
            if (addr_step)
                addr <= addr + 1'b1;
            if (finish_ok) begin
                busy         <= 1'b0;
                done         <= 1'b1;
                core_reset_n <= 1'b1;
            end
            if (finish_bad)
                busy <= 1'b0;
        end
    end

`ifdef LOADER_CHKSUM_EN
    logic [7:0] chk_acc;

    assign chk_match = (byte_data == chk_acc);

    // Running XOR of the data bytes and the sticky checksum error flag.
    always_ff @(posedge reloj) begin
        if (!resetM) begin
            chk_acc <= 8'd0;
            err     <= 1'b0;
        end else begin
            if (start_load)
                err <= 1'b0;
            if (len_take)
                chk_acc <= 8'd0;
            else if (data_take)
                chk_acc <= chk_acc ^ byte_data;
            if (finish_bad)
                err <= 1'b1;
        end
    end
`else
    assign chk_match = 1'b1;
    assign err       = 1'b0;
`endif

endmodule
